// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t  : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   res_t    : packed {g, e, l} result code and its constant values
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [2:0] res_t;

  localparam res_t RES_NONE = 3'b000;
  localparam res_t RES_GT   = 3'b100;
  localparam res_t RES_EQ   = 3'b010;
  localparam res_t RES_LT   = 3'b001;

endpackage

// File: rtl/comparator_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
//   x, y    : slice of operand A and operand B
//   g, e, l : x>y, x==y, x<y (exactly one is high)
module comparator_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             g,
  output logic             e,
  output logic             l
);

  assign g = (x > y);
  assign e = (x == y);
  assign l = (x < y);

endmodule

// File: rtl/comparator_serial.sv
// Serial MSB-first comparator: compares WIDTH-bit operands CHUNK bits per
// cycle, stopping at the first unequal chunk.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : begin a compare (accepted only when idle)
//   a, b           : operands, latched on the accepting edge
//   signed_mode    : 1 = two's-complement compare, 0 = unsigned
//   busy           : high while running and during the done cycle
//   done           : one-cycle pulse when g/e/l hold a fresh result
//   g, e, l        : registered A>B, A==B, A<B
module comparator_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l
);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $fatal(1, "comparator_serial: WIDTH must be a multiple of CHUNK");
  end

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NCHUNK - 1);

  // Assertion is asynchronous; release is re-timed to clk through two flops.
  logic [1:0] rst_sync_q;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_i = rst_sync_q[1];

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              sgn_q;
  logic [IDXW-1:0]   idx_q;
  res_t              res_q;

  logic [CHUNK-1:0]  ca, cb;
  logic              cg, ce, cl;

  // Index-selected slice; signed mode flips the operand sign bits so the
  // top chunk can be compared as unsigned.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
    if (sgn_q && (idx_q == TOP_IDX)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
  end

  comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x (ca),
    .y (cb),
    .g (cg),
    .e (ce),
    .l (cl)
  );

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (!ce || (idx_q == '0)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      idx_q <= '0;
      res_q <= RES_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= signed_mode;
            idx_q <= TOP_IDX;
          end
        end
        ST_RUN: begin
          if (!ce)              res_q <= cg ? RES_GT : RES_LT;
          else if (idx_q == '0) res_q <= RES_EQ;
          else                  idx_q <= idx_q - IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign {g, e, l} = res_q;

  logic unused_cl;
  assign unused_cl = cl;

endmodule
